// File: rtl/hevc_interp_pkg.sv
// Shared constants and loader state type for the interpolation window buffer.
// Also holds the helper that tells whether the current row closes its section.
package hevc_interp_pkg;

    localparam int NUM_PIXEL   = 8;
    localparam int PIXEL_BITS  = 8;
    localparam int ROW_PIXELS  = NUM_PIXEL + 7;
    localparam int ROW_BITS    = ROW_PIXELS * PIXEL_BITS;
    localparam int INT_ROWS    = NUM_PIXEL + 7;
    localparam int HALF_B_ROWS = NUM_PIXEL;
    localparam int CNT_W       = $clog2(INT_ROWS);
    localparam int HB_IDX_W    = $clog2(HALF_B_ROWS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_INT = 2'd1,
        LOAD_HB  = 2'd2,
        READY    = 2'd3
    } loader_state_t;

    // Section size is the only thing that ends a section; row_last is merely checked against it.
    function automatic logic section_last(input loader_state_t st, input logic [CNT_W-1:0] cnt);
        logic last;
        case (st)
            LOAD_INT: last = (cnt == CNT_W'(INT_ROWS - 1));
            LOAD_HB:  last = (cnt == CNT_W'(HALF_B_ROWS - 1));
            default:  last = 1'b0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/row_bank_writer.sv
// Flattened row bank: one indexed row is written per enabled cycle, whole bank
// clears synchronously. Outputs are the storage registers themselves.
module row_bank_writer #(
    parameter int ROWS     = 15,
    parameter int ROW_BITS = 120,
    localparam int IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [ROW_BITS-1:0]      wr_data,
    output logic [ROWS*ROW_BITS-1:0] bank
);

    // Row storage: clear wins over write; unwritten rows hold their value.
    always_ff @(posedge clock) begin
        if (clear) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[int'(wr_idx)*ROW_BITS +: ROW_BITS] <= wr_data;
        end
    end

endmodule

// File: rtl/ref_window_loader.sv
// Write side of the interpolation window buffer: assembles streamed rows into the
// integer and half-B row banks and holds them valid until the consumer releases them.
module ref_window_loader
    import hevc_interp_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ROW_BITS-1:0]             row_data,
    input  logic                            row_valid,
    input  logic                            row_last,
    output logic                            row_ready,
    input  logic                            consumer_done,
    output logic [INT_ROWS*ROW_BITS-1:0]    integer_array,
    output logic [HALF_B_ROWS*ROW_BITS-1:0] b_half_array,
    output logic                            arrays_valid,
    output logic                            busy,
    output logic                            error
);

    loader_state_t    state_r;
    logic [CNT_W-1:0] row_cnt_r;
    logic             row_ready_r;
    logic             arrays_valid_r;
    logic             busy_r;
    logic             error_r;
    logic             hs_s;
    logic             int_we_s;
    logic             hb_we_s;
    logic             final_s;

    // Handshake decode and per-bank write enables.
    always_comb begin
        hs_s     = row_valid && row_ready_r;
        int_we_s = hs_s && (state_r == LOAD_INT);
        hb_we_s  = hs_s && (state_r == LOAD_HB);
        final_s  = section_last(state_r, row_cnt_r);
    end

    // Loader FSM with row counter, sticky row_last check and registered flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            row_cnt_r      <= {CNT_W{1'b0}};
            row_ready_r    <= 1'b0;
            arrays_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= LOAD_INT;
                        row_cnt_r   <= {CNT_W{1'b0}};
                        row_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        error_r     <= 1'b0;
                    end
                end
                LOAD_INT: begin
                    if (hs_s) begin
                        error_r <= error_r | (row_last ^ final_s);
                        if (final_s) begin
                            state_r   <= LOAD_HB;
                            row_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            row_cnt_r <= row_cnt_r + CNT_W'(1);
                        end
                    end
                end
                LOAD_HB: begin
                    if (hs_s) begin
                        error_r <= error_r | (row_last ^ final_s);
                        if (final_s) begin
                            state_r        <= READY;
                            row_cnt_r      <= {CNT_W{1'b0}};
                            row_ready_r    <= 1'b0;
                            arrays_valid_r <= 1'b1;
                        end else begin
                            row_cnt_r <= row_cnt_r + CNT_W'(1);
                        end
                    end
                end
                READY: begin
                    // A start arriving with consumer_done is dropped on purpose.
                    if (consumer_done) begin
                        state_r        <= IDLE;
                        arrays_valid_r <= 1'b0;
                        busy_r         <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    row_cnt_r      <= {CNT_W{1'b0}};
                    row_ready_r    <= 1'b0;
                    arrays_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    error_r        <= 1'b0;
                end
            endcase
        end
    end

    row_bank_writer #(
        .ROWS     (INT_ROWS),
        .ROW_BITS (ROW_BITS)
    ) u_int_bank (
        .clock   (clock),
        .clear   (reset),
        .wr_en   (int_we_s),
        .wr_idx  (row_cnt_r),
        .wr_data (row_data),
        .bank    (integer_array)
    );

    row_bank_writer #(
        .ROWS     (HALF_B_ROWS),
        .ROW_BITS (ROW_BITS)
    ) u_hb_bank (
        .clock   (clock),
        .clear   (reset),
        .wr_en   (hb_we_s),
        .wr_idx  (row_cnt_r[HB_IDX_W-1:0]),
        .wr_data (row_data),
        .bank    (b_half_array)
    );

    assign row_ready    = row_ready_r;
    assign arrays_valid = arrays_valid_r;
    assign busy         = busy_r;
    assign error        = error_r;

endmodule
